mem_port_arbiter: RTL and testbench

Shares one single-port memory between the instruction-fetch port (I, read-only) and the load/store port (D, read/write) of the RISC-V core. It is the step toward a unified instruction/data memory. The block accepts one request at a time, forwards it downstream as a command, waits for the memory response and routes that response back to the requester that owns it. Arbitration is round-robin, and only one transaction is outstanding at any time.

---
 rtl/mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch port (I, read
// only) and the load/store port (D, read/write). One request is accepted at a
// time, forwarded downstream as a command, and the single memory response is
// routed back to the port that owns the transaction. Ties are resolved
// round-robin against the last granted port.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Adds a response watchdog of TIMEOUT WAIT cycles and the sticky output
//   ARB_timeout. Without the macro WAIT holds until the memory responds.
//
// Ports:
//   SYS_clk, SYS_reset        clock, asynchronous active-high reset
//   I_req_valid/addr          fetch request in
//   I_req_ready               fetch request accepted (combinational, IDLE only)
//   I_rsp_valid/data          fetch response, one-cycle pulse
//   D_req_valid/write/length  data request in (length 01 byte, 10 half, 11 word)
//   D_req_addr/wdata          data request address / store data
//   D_req_ready               data request accepted (combinational, IDLE only)
//   D_rsp_valid/data          data response, one-cycle pulse (data 0 for stores)
//   M_cmd_*                   downstream command, held while not accepted
//   M_cmd_ready               memory accepts the command
//   M_rsp_valid/data          memory response, one per command
//   ARB_timeout               sticky watchdog flag (ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,

    input  logic              I_req_valid,
    input  logic [ADDR_W-1:0] I_req_addr,
    output logic              I_req_ready,
    output logic              I_rsp_valid,
    output logic [DATA_W-1:0] I_rsp_data,

    input  logic              D_req_valid,
    input  logic              D_req_write,
    input  logic [1:0]        D_req_length,
    input  logic [ADDR_W-1:0] D_req_addr,
    input  logic [DATA_W-1:0] D_req_wdata,
    output logic              D_req_ready,
    output logic              D_rsp_valid,
    output logic [DATA_W-1:0] D_rsp_data,

    output logic              M_cmd_valid,
    output logic              M_cmd_write,
    output logic [1:0]        M_cmd_length,
    output logic [ADDR_W-1:0] M_cmd_addr,
    output logic [DATA_W-1:0] M_cmd_wdata,
    input  logic              M_cmd_ready,
    input  logic              M_rsp_valid,
    input  logic [DATA_W-1:0] M_rsp_data
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              ARB_timeout
`endif
);

    // FSM encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    // Port identifiers used by owner / last_grant
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Fetches are always full-word reads
    localparam logic [1:0] LEN_WORD = 2'b11;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last_grant;
    logic       owner;
    logic       grant_i;
    logic       grant_d;
    logic       rsp_done;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;
`else
    // TIMEOUT has no effect when the watchdog is not built
    if (TIMEOUT == 0) begin : g_no_watchdog
    end
`endif

    // State register
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant and response-complete decode
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        rsp_done  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                // I wins when alone, or on a tie when D was served last
                if (I_req_valid && (!D_req_valid || last_grant == PORT_D)) begin
                    grant_i   = 1'b1;
                    state_nxt = ISSUE;
                end else if (D_req_valid) begin
                    grant_d   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (M_cmd_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A real response takes priority over an expiring watchdog
                if (M_rsp_valid) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign I_req_ready = grant_i;
    assign D_req_ready = grant_d;

    // Command latch, ownership, round-robin history and response registers
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            last_grant   <= PORT_D;
            owner        <= PORT_I;
            M_cmd_valid  <= 1'b0;
            M_cmd_write  <= 1'b0;
            M_cmd_length <= 2'b00;
            M_cmd_addr   <= '0;
            M_cmd_wdata  <= '0;
            I_rsp_valid  <= 1'b0;
            I_rsp_data   <= '0;
            D_rsp_valid  <= 1'b0;
            D_rsp_data   <= '0;
        end else begin
            // Response outputs are single-cycle pulses
            I_rsp_valid <= 1'b0;
            I_rsp_data  <= '0;
            D_rsp_valid <= 1'b0;
            D_rsp_data  <= '0;

            if (grant_i) begin
                M_cmd_valid  <= 1'b1;
                M_cmd_write  <= 1'b0;
                M_cmd_length <= LEN_WORD;
                M_cmd_addr   <= I_req_addr;
                M_cmd_wdata  <= '0;
                owner        <= PORT_I;
                last_grant   <= PORT_I;
            end else if (grant_d) begin
                M_cmd_valid  <= 1'b1;
                M_cmd_write  <= D_req_write;
                M_cmd_length <= D_req_length;
                M_cmd_addr   <= D_req_addr;
                M_cmd_wdata  <= D_req_wdata;
                owner        <= PORT_D;
                last_grant   <= PORT_D;
            end else if (state == ISSUE && M_cmd_ready) begin
                M_cmd_valid <= 1'b0;
            end

            if (rsp_done) begin
                if (owner == PORT_I) begin
                    I_rsp_valid <= 1'b1;
                    I_rsp_data  <= M_rsp_data;
                end else begin
                    D_rsp_valid <= 1'b1;
                    // Stores return no data; the command write bit is still held
                    D_rsp_data  <= M_cmd_write ? '0 : M_rsp_data;
                end
            end

`ifdef ARB_TIMEOUT_EN
            // Watchdog expiry completes the transaction with zero data
            if (timeout_hit) begin
                if (owner == PORT_I) begin
                    I_rsp_valid <= 1'b1;
                end else begin
                    D_rsp_valid <= 1'b1;
                end
            end
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT-cycle counter, cleared while the command is being issued
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            ARB_timeout <= 1'b0;
        end else if (timeout_hit) begin
            ARB_timeout <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter: a directed vector table of single
// transactions, hand-written sequences for reset, stray responses and
// round-robin ties, and a randomized run checked against a transaction-level
// model of two requesters with pending requests. With ARB_TIMEOUT_EN the
// watchdog is exercised with TIMEOUT = 8.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 64;
`endif

    logic        SYS_clk;
    logic        SYS_reset;
    logic        I_req_valid;
    logic [31:0] I_req_addr;
    logic        I_req_ready;
    logic        I_rsp_valid;
    logic [31:0] I_rsp_data;
    logic        D_req_valid;
    logic        D_req_write;
    logic [1:0]  D_req_length;
    logic [31:0] D_req_addr;
    logic [31:0] D_req_wdata;
    logic        D_req_ready;
    logic        D_rsp_valid;
    logic [31:0] D_rsp_data;
    logic        M_cmd_valid;
    logic        M_cmd_write;
    logic [1:0]  M_cmd_length;
    logic [31:0] M_cmd_addr;
    logic [31:0] M_cmd_wdata;
    logic        M_cmd_ready;
    logic        M_rsp_valid;
    logic [31:0] M_rsp_data;
`ifdef ARB_TIMEOUT_EN
    logic        ARB_timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .I_req_valid (I_req_valid),
        .I_req_addr  (I_req_addr),
        .I_req_ready (I_req_ready),
        .I_rsp_valid (I_rsp_valid),
        .I_rsp_data  (I_rsp_data),
        .D_req_valid (D_req_valid),
        .D_req_write (D_req_write),
        .D_req_length(D_req_length),
        .D_req_addr  (D_req_addr),
        .D_req_wdata (D_req_wdata),
        .D_req_ready (D_req_ready),
        .D_rsp_valid (D_rsp_valid),
        .D_rsp_data  (D_rsp_data),
        .M_cmd_valid (M_cmd_valid),
        .M_cmd_write (M_cmd_write),
        .M_cmd_length(M_cmd_length),
        .M_cmd_addr  (M_cmd_addr),
        .M_cmd_wdata (M_cmd_wdata),
        .M_cmd_ready (M_cmd_ready),
        .M_rsp_valid (M_rsp_valid),
        .M_rsp_data  (M_rsp_data)
`ifdef ARB_TIMEOUT_EN
        ,
        .ARB_timeout (ARB_timeout)
`endif
    );

    initial SYS_clk = 1'b0;
    always #5 SYS_clk = ~SYS_clk;

    // Single directed transaction with its expected downstream command/response
    typedef struct {
        bit        is_d;
        bit        write;
        bit [1:0]  len;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        cmd_wait;
        int        rsp_lat;
        bit        exp_write;
        bit [1:0]  exp_len;
        bit [31:0] exp_rsp;
    } vec_t;

    // Pending request held by one requester in the random model
    typedef struct {
        bit        valid;
        bit        write;
        bit [1:0]  len;
        bit [31:0] addr;
        bit [31:0] wdata;
    } req_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge SYS_clk);
        #1;
    endtask

    task automatic do_reset();
        SYS_reset    = 1'b1;
        I_req_valid  = 1'b0;
        I_req_addr   = '0;
        D_req_valid  = 1'b0;
        D_req_write  = 1'b0;
        D_req_length = 2'b00;
        D_req_addr   = '0;
        D_req_wdata  = '0;
        M_cmd_ready  = 1'b0;
        M_rsp_valid  = 1'b0;
        M_rsp_data   = '0;
        tick();
        tick();
        SYS_reset = 1'b0;
    endtask

    task automatic drive_reqs(input req_t pi, input req_t pd);
        I_req_valid  = pi.valid;
        I_req_addr   = pi.addr;
        D_req_valid  = pd.valid;
        D_req_write  = pd.write;
        D_req_length = pd.len;
        D_req_addr   = pd.addr;
        D_req_wdata  = pd.wdata;
    endtask

    // Run one isolated transaction from an IDLE cycle and check every cycle
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            D_req_valid  = 1'b1;
            D_req_write  = v.write;
            D_req_length = v.len;
            D_req_addr   = v.addr;
            D_req_wdata  = v.wdata;
        end else begin
            I_req_valid  = 1'b1;
            I_req_addr   = v.addr;
            D_req_addr   = ~v.addr;
            D_req_wdata  = 32'h5A5A_5A5A;
        end
        @(negedge SYS_clk);
        chk({tag, " ready"}, 64'({I_req_ready, D_req_ready}), 64'(v.is_d ? 2'b01 : 2'b10));
        tick();
        I_req_valid = 1'b0;
        D_req_valid = 1'b0;
        for (int c = 0; c <= v.cmd_wait; c++) begin
            M_cmd_ready = (c == v.cmd_wait);
            @(negedge SYS_clk);
            chk({tag, " cmd"}, 64'({M_cmd_valid, M_cmd_write, M_cmd_length, M_cmd_addr}),
                64'({1'b1, v.exp_write, v.exp_len, v.addr}));
            if (v.is_d) chk({tag, " wdata"}, 64'(M_cmd_wdata), 64'(v.wdata));
            tick();
        end
        M_cmd_ready = 1'b0;
        for (int c = 0; c <= v.rsp_lat; c++) begin
            M_rsp_valid = (c == v.rsp_lat);
            M_rsp_data  = v.rdata;
            @(negedge SYS_clk);
            chk({tag, " wait"}, 64'({M_cmd_valid, I_rsp_valid, D_rsp_valid}), 64'(0));
            tick();
        end
        M_rsp_valid = 1'b0;
        M_rsp_data  = '0;
        @(negedge SYS_clk);
        chk({tag, " rsp valid"}, 64'({I_rsp_valid, D_rsp_valid}), 64'(v.is_d ? 2'b01 : 2'b10));
        chk({tag, " rsp data"}, 64'({I_rsp_data, D_rsp_data}),
            v.is_d ? 64'({32'h0, v.exp_rsp}) : 64'({v.exp_rsp, 32'h0}));
        tick();
    endtask

    // Abort guard in case the sequence logic ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        req_t      pi;
        req_t      pd;
        req_t      cur;
        bit        last_d;
        bit        exp_d;
        bit        prev_valid;
        bit        prev_d;
        bit [31:0] prev_data;
        bit [31:0] rdata;
        int        cw;
        int        rl;

        //           is_d write len    addr          wdata         rdata         cw rl ew len    exp_rsp
        vecs[0] = '{1'b0, 1'b0, 2'b11, 32'h0000_0040, 32'h0,        32'h0000_0013, 0, 0, 1'b0, 2'b11, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b1, 2'b01, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1234_5678, 3, 1, 1'b1, 2'b01, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 2'b10, 32'h0000_0202, 32'h0,        32'hCAFE_F00D, 1, 2, 1'b0, 2'b10, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b1, 2'b01, 32'h0000_0044, 32'h0,        32'hFFFF_FFFF, 2, 0, 1'b0, 2'b11, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 2'b11, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 0, 3, 1'b0, 2'b11, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h0000_0008, 32'h0000_0001, 32'h0000_FFFF, 0, 0, 1'b1, 2'b11, 32'h0};

        // Reset values
        do_reset();
        @(negedge SYS_clk);
        chk("reset ctrl", 64'({I_req_ready, D_req_ready, I_rsp_valid, D_rsp_valid,
                               M_cmd_valid, M_cmd_write, M_cmd_length}), 64'(0));
        chk("reset cmd", 64'({M_cmd_addr, M_cmd_wdata}), 64'(0));
        chk("reset rsp", 64'({I_rsp_data, D_rsp_data}), 64'(0));
`ifdef ARB_TIMEOUT_EN
        chk("reset timeout", 64'(ARB_timeout), 64'(0));
`endif
        tick();

        // Stray response while IDLE is ignored
        M_rsp_valid = 1'b1;
        M_rsp_data  = 32'h5555_5555;
        tick();
        M_rsp_valid = 1'b0;
        @(negedge SYS_clk);
        chk("stray idle", 64'({I_rsp_valid, D_rsp_valid, M_cmd_valid, I_req_ready, D_req_ready}), 64'(0));
        tick();

        // Directed vector table
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Both ports request continuously from reset: strict alternation I, D, I, D
        do_reset();
        I_req_valid  = 1'b1;
        I_req_addr   = 32'h0000_1000;
        D_req_valid  = 1'b1;
        D_req_write  = 1'b0;
        D_req_length = 2'b11;
        D_req_addr   = 32'h0000_2000;
        M_cmd_ready  = 1'b1;
        last_d       = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_d = !last_d;
            @(negedge SYS_clk);
            chk($sformatf("tie grant%0d", g), 64'({I_req_ready, D_req_ready}), 64'(exp_d ? 2'b01 : 2'b10));
            last_d = exp_d;
            tick();
            @(negedge SYS_clk);
            chk($sformatf("tie addr%0d", g), 64'(M_cmd_addr), 64'(exp_d ? 32'h0000_2000 : 32'h0000_1000));
            tick();
            M_rsp_valid = 1'b1;
            M_rsp_data  = 32'(g);
            tick();
            M_rsp_valid = 1'b0;
        end
        I_req_valid = 1'b0;
        D_req_valid = 1'b0;
        M_cmd_ready = 1'b0;
        tick();

        // Reset while a fetch waits for its response, then a late response
        I_req_valid = 1'b1;
        I_req_addr  = 32'h0000_0300;
        @(negedge SYS_clk);
        chk("rstwait grant", 64'({I_req_ready, D_req_ready}), 64'(2'b10));
        tick();
        I_req_valid = 1'b0;
        M_cmd_ready = 1'b1;
        tick();
        M_cmd_ready = 1'b0;
        @(negedge SYS_clk);
        chk("rstwait in wait", 64'({M_cmd_valid, I_rsp_valid, D_rsp_valid}), 64'(0));
        #2 SYS_reset = 1'b1;
        #1;
        chk("rstwait async", 64'({M_cmd_valid, M_cmd_addr, I_rsp_valid, D_rsp_valid}), 64'(0));
        tick();
        SYS_reset   = 1'b0;
        M_rsp_valid = 1'b1;
        M_rsp_data  = 32'h0000_00AA;
        tick();
        M_rsp_valid = 1'b0;
        @(negedge SYS_clk);
        chk("rstwait late rsp", 64'({I_rsp_valid, D_rsp_valid, M_cmd_valid, I_rsp_data, D_rsp_data}), 64'(0));
        tick();
        I_req_valid  = 1'b1;
        I_req_addr   = 32'h0000_0500;
        D_req_valid  = 1'b1;
        D_req_addr   = 32'h0000_0600;
        @(negedge SYS_clk);
        chk("rstwait tie to I", 64'({I_req_ready, D_req_ready}), 64'(2'b10));
        tick();

        // Randomized traffic against a transaction-level model
        do_reset();
        last_d     = 1'b1;
        prev_valid = 1'b0;
        prev_d     = 1'b0;
        prev_data  = '0;
        pi         = '{default: '0};
        pd         = '{default: '0};
        for (int r = 0; r < 150; r++) begin
            if (!pi.valid && $urandom_range(0, 2) != 0) begin
                pi.valid = 1'b1;
                pi.addr  = $urandom;
            end
            if (!pd.valid && $urandom_range(0, 2) != 0) begin
                pd.valid = 1'b1;
                pd.write = 1'($urandom_range(0, 1));
                pd.len   = 2'($urandom_range(1, 3));
                pd.addr  = $urandom;
                pd.wdata = $urandom;
            end
            if (!pi.valid && !pd.valid) begin
                pi.valid = 1'b1;
                pi.addr  = $urandom;
            end
            drive_reqs(pi, pd);
            exp_d = pd.valid && (!pi.valid || !last_d);
            @(negedge SYS_clk);
            if (prev_valid) begin
                chk("rand rsp valid", 64'({I_rsp_valid, D_rsp_valid}), 64'(prev_d ? 2'b01 : 2'b10));
                chk("rand rsp data", 64'({I_rsp_data, D_rsp_data}),
                    prev_d ? 64'({32'h0, prev_data}) : 64'({prev_data, 32'h0}));
            end else begin
                chk("rand rsp idle", 64'({I_rsp_valid, D_rsp_valid}), 64'(0));
            end
            chk("rand grant", 64'({I_req_ready, D_req_ready}), 64'(exp_d ? 2'b01 : 2'b10));
            cur    = exp_d ? pd : pi;
            last_d = exp_d;
            if (exp_d) pd.valid = 1'b0;
            else       pi.valid = 1'b0;
            tick();
            drive_reqs(pi, pd);
            cw    = int'($urandom_range(0, 3));
            rl    = int'($urandom_range(0, 3));
            rdata = $urandom;
            for (int c = 0; c <= cw; c++) begin
                M_cmd_ready = (c == cw);
                M_rsp_valid = ($urandom_range(0, 4) == 0);
                M_rsp_data  = $urandom;
                @(negedge SYS_clk);
                chk("rand cmd", 64'({M_cmd_valid, M_cmd_write, M_cmd_length, M_cmd_addr}),
                    exp_d ? 64'({1'b1, cur.write, cur.len, cur.addr})
                          : 64'({1'b1, 1'b0, 2'b11, cur.addr}));
                if (exp_d) chk("rand wdata", 64'(M_cmd_wdata), 64'(cur.wdata));
                chk("rand issue quiet", 64'({I_req_ready, D_req_ready, I_rsp_valid, D_rsp_valid}), 64'(0));
                tick();
            end
            M_cmd_ready = 1'b0;
            for (int c = 0; c <= rl; c++) begin
                M_rsp_valid = (c == rl);
                M_rsp_data  = rdata;
                @(negedge SYS_clk);
                chk("rand wait quiet", 64'({M_cmd_valid, I_req_ready, D_req_ready, I_rsp_valid, D_rsp_valid}), 64'(0));
                tick();
            end
            M_rsp_valid = 1'b0;
            prev_valid  = 1'b1;
            prev_d      = exp_d;
            prev_data   = (exp_d && cur.write) ? 32'h0 : rdata;
        end
        I_req_valid = 1'b0;
        D_req_valid = 1'b0;
        @(negedge SYS_clk);
        chk("rand last rsp", 64'({I_rsp_valid, D_rsp_valid}), 64'(prev_d ? 2'b01 : 2'b10));
        tick();

`ifdef ARB_TIMEOUT_EN
        // D load that never gets a response: watchdog completes it
        do_reset();
        D_req_valid  = 1'b1;
        D_req_write  = 1'b0;
        D_req_length = 2'b11;
        D_req_addr   = 32'h0000_0700;
        @(negedge SYS_clk);
        chk("to grant", 64'({I_req_ready, D_req_ready}), 64'(2'b01));
        tick();
        D_req_valid = 1'b0;
        M_cmd_ready = 1'b1;
        tick();
        M_cmd_ready = 1'b0;
        for (int w = 0; w < 8; w++) begin
            @(negedge SYS_clk);
            chk($sformatf("to wait%0d", w), 64'({D_rsp_valid, I_rsp_valid, ARB_timeout}), 64'(0));
            tick();
        end
        @(negedge SYS_clk);
        chk("to pulse", 64'({D_rsp_valid, I_rsp_valid, D_rsp_data, ARB_timeout}), 64'({1'b1, 1'b0, 32'h0, 1'b1}));
        tick();
        run_vec(9, vecs[2]);
        chk("to sticky", 64'(ARB_timeout), 64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
